// File: rtl/bram_burst_reader.sv
// Burst read engine for BRAM port B: reads burst_len consecutive words (wrapping at
// MEM_DEPTH) and streams them out, with a skid FIFO that absorbs reads still in flight.
module bram_burst_reader #(
   parameter int DATA_BITS  = 512,
   parameter int ADDR_BITS  = 10,
   parameter int MEM_DEPTH  = 1024,
   parameter int RD_LATENCY = 2,
   parameter int LEN_BITS   = 11
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [ADDR_BITS-1:0] start_addr,
   input  logic [LEN_BITS-1:0]  burst_len,
   input  logic                 abort,
   output logic                 busy,
   output logic                 done,
   output logic                 aborted,
   output logic                 len_error,
   output logic [ADDR_BITS-1:0] address_b,
   output logic                 enb,
   output logic                 web,
   input  logic [DATA_BITS-1:0] doutb,
   output logic [DATA_BITS-1:0] fifo_tx_data,
   output logic                 fifo_tx_valid,
   input  logic                 fifo_tx_ready,
   output logic [2:0]           dbg_state
);

   // Stream handshake: a word moves when fifo_tx_valid && fifo_tx_ready on a rising edge;
   // while valid is high and ready low, valid stays high and data holds (abort/reset excepted).

   localparam int SKID_DEPTH = RD_LATENCY + 2;
   localparam int PTR_BITS   = $clog2(SKID_DEPTH);
   localparam int CNT_BITS   = $clog2(SKID_DEPTH + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_DRAIN = 3'd2;
   localparam logic [2:0] S_FLUSH = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]           state_q, state_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [LEN_BITS-1:0]  rd_rem_q, rd_rem_d;
   logic [LEN_BITS-1:0]  xf_rem_q, xf_rem_d;
   logic [RD_LATENCY-1:0] pend_q, pend_d;
   logic [1:0]           flush_cnt_q, flush_cnt_d;
   logic                 aborted_q, aborted_d;
   logic                 len_err_q, len_err_d;
   logic [PTR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_BITS-1:0]  cnt_q, cnt_d;
   logic [DATA_BITS-1:0] mem_q [SKID_DEPTH];

   logic issue, push, pop, len_ok, flush_go;
   int   occupancy;

   function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
      return (p == PTR_BITS'(SKID_DEPTH - 1)) ? '0 : p + PTR_BITS'(1);
   endfunction

   // A read may only be issued when a FIFO slot is already reserved for its data.
   always_comb begin
      occupancy = int'(cnt_q);
      for (int i = 0; i < RD_LATENCY; i++) begin
         occupancy = occupancy + int'(pend_q[i]);
      end
   end

   assign len_ok   = (burst_len != '0) && (int'(burst_len) <= MEM_DEPTH);
   assign issue    = (state_q == S_READ) && !abort && (occupancy < SKID_DEPTH);
   assign push     = pend_q[RD_LATENCY-1] && (state_q != S_FLUSH);
   assign pop      = fifo_tx_valid && fifo_tx_ready;
   assign flush_go = abort && ((state_q == S_READ) || (state_q == S_DRAIN));

   always_comb begin
      pend_d[0] = issue;
      for (int i = 1; i < RD_LATENCY; i++) begin
         pend_d[i] = pend_q[i-1];
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush_go) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         cnt_d = cnt_q + CNT_BITS'(push) - CNT_BITS'(pop);
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rd_rem_d    = rd_rem_q;
      xf_rem_d    = pop ? (xf_rem_q - LEN_BITS'(1)) : xf_rem_q;
      flush_cnt_d = flush_cnt_q;
      aborted_d   = aborted_q;
      len_err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (len_ok) begin
                  state_d   = S_READ;
                  addr_d    = start_addr;
                  rd_rem_d  = burst_len;
                  xf_rem_d  = burst_len;
                  aborted_d = 1'b0;
               end else begin
                  len_err_d = 1'b1;
               end
            end
         end
         S_READ: begin
            if (abort) begin
               state_d     = S_FLUSH;
               flush_cnt_d = '0;
               aborted_d   = 1'b1;
            end else if (issue) begin
               addr_d   = (addr_q == ADDR_BITS'(MEM_DEPTH - 1)) ? '0 : addr_q + ADDR_BITS'(1);
               rd_rem_d = rd_rem_q - LEN_BITS'(1);
               if (rd_rem_q == LEN_BITS'(1)) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (abort) begin
               state_d     = S_FLUSH;
               flush_cnt_d = '0;
               aborted_d   = 1'b1;
            end else if (pop && (xf_rem_q == LEN_BITS'(1))) begin
               state_d = S_DONE;
            end
         end
         S_FLUSH: begin
            // Reads issued before the abort keep landing for RD_LATENCY cycles; drop them.
            flush_cnt_d = flush_cnt_q + 2'd1;
            if (flush_cnt_q == 2'(RD_LATENCY - 1)) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         rd_rem_q    <= '0;
         xf_rem_q    <= '0;
         pend_q      <= '0;
         flush_cnt_q <= '0;
         aborted_q   <= 1'b0;
         len_err_q   <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rd_rem_q    <= rd_rem_d;
         xf_rem_q    <= xf_rem_d;
         pend_q      <= pend_d;
         flush_cnt_q <= flush_cnt_d;
         aborted_q   <= aborted_d;
         len_err_q   <= len_err_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= doutb;
   end

   assign fifo_tx_valid = (cnt_q != '0);
   assign fifo_tx_data  = fifo_tx_valid ? mem_q[rd_ptr_q] : '0;
   assign busy          = (state_q != S_IDLE);
   assign done          = (state_q == S_DONE);
   assign aborted       = done && aborted_q;
   assign len_error     = len_err_q;
   assign address_b     = addr_q;
   assign enb           = issue;
   assign web           = 1'b0;
   assign dbg_state     = state_q;

endmodule
